// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : RV32I decode stage. Decodes the IF/ID instruction into control
//            signals and a sign-extended immediate, reads the 32-entry
//            register file (with same-cycle writeback bypass) and registers
//            everything into the ID/EX pipeline register. ID/EX is cleared
//            to a bubble on a taken branch/jump or a hazard-unit flush.
// Ports    : clk, rst_n (async, active-low)
//            Ins_D/PC_D/PC_4D          IF/ID instruction, PC, PC+4
//            RegWrite_W/Rd_W/Result_W  writeback port
//            PCSrc_E, ID_EX_Flush      ID/EX bubble requests
//            Rs1_D/Rs2_D               combinational source indices
//            *_E                       registered ID/EX outputs
// Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Ins_D,
  input  logic [ADDR_WIDTH-1:0] PC_D,
  input  logic [ADDR_WIDTH-1:0] PC_4D,
  input  logic                  RegWrite_W,
  input  logic [4:0]            Rd_W,
  input  logic [ADDR_WIDTH-1:0] Result_W,
  input  logic                  PCSrc_E,
  input  logic                  ID_EX_Flush,
  output logic [4:0]            Rs1_D,
  output logic [4:0]            Rs2_D,
  output logic                  RegWrite_E,
  output logic                  MemWrite_E,
  output logic                  Jump_E,
  output logic                  Branch_E,
  output logic                  ALUSrc_E,
  output logic [1:0]            ResultSrc_E,
  output logic [2:0]            ALUControl_E,
  output logic [2:0]            funct3_E,
  output logic [ADDR_WIDTH-1:0] RD1_E,
  output logic [ADDR_WIDTH-1:0] RD2_E,
  output logic [ADDR_WIDTH-1:0] Imm_Ext_E,
  output logic [ADDR_WIDTH-1:0] PC_E,
  output logic [ADDR_WIDTH-1:0] PC_4E,
  output logic [4:0]            Rd_E,
  output logic [4:0]            Rs1_E,
  output logic [4:0]            Rs2_E
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_IALU   = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_SUB  = 3'b001;
  localparam logic [2:0] c_ALU_AND  = 3'b010;
  localparam logic [2:0] c_ALU_OR   = 3'b011;
  localparam logic [2:0] c_ALU_XOR  = 3'b100;
  localparam logic [2:0] c_ALU_SLT  = 3'b101;
  localparam logic [2:0] c_ALU_SLL  = 3'b110;
  localparam logic [2:0] c_ALU_PASS = 3'b111;

  // --------------------------------------------------------------------------
  // Instruction fields and immediates
  // --------------------------------------------------------------------------
  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [4:0]            w_rd;
  logic [ADDR_WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;

  assign w_opcode = Ins_D[6:0];
  assign w_rd     = Ins_D[11:7];
  assign w_funct3 = Ins_D[14:12];
  assign Rs1_D    = Ins_D[19:15];
  assign Rs2_D    = Ins_D[24:20];

  assign w_imm_i = {{(ADDR_WIDTH-12){Ins_D[31]}}, Ins_D[31:20]};
  assign w_imm_s = {{(ADDR_WIDTH-12){Ins_D[31]}}, Ins_D[31:25], Ins_D[11:7]};
  assign w_imm_b = {{(ADDR_WIDTH-13){Ins_D[31]}}, Ins_D[31], Ins_D[7],
                    Ins_D[30:25], Ins_D[11:8], 1'b0};
  assign w_imm_j = {{(ADDR_WIDTH-21){Ins_D[31]}}, Ins_D[31], Ins_D[19:12],
                    Ins_D[20], Ins_D[30:21], 1'b0};
  // Bit 31 is the top of the U field; the replication covers sign extension.
  assign w_imm_u = {{(ADDR_WIDTH-31){Ins_D[31]}}, Ins_D[30:12], 12'b0};

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic                  w_reg_write, w_mem_write, w_jump, w_branch, w_alu_src;
  logic [1:0]            w_result_src;
  logic [2:0]            w_alu_ctl;
  logic [2:0]            w_alu_func;
  logic [ADDR_WIDTH-1:0] w_imm;

  // ALU operation shared by R-type and I-ALU; sub only exists for R-type.
  always_comb begin
    w_alu_func = c_ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_func = (w_opcode == c_OP_RTYPE && Ins_D[30]) ? c_ALU_SUB : c_ALU_ADD;
      3'b001:  w_alu_func = c_ALU_SLL;
      3'b010:  w_alu_func = c_ALU_SLT;
      3'b100:  w_alu_func = c_ALU_XOR;
      3'b110:  w_alu_func = c_ALU_OR;
      3'b111:  w_alu_func = c_ALU_AND;
      default: w_alu_func = c_ALU_ADD;
    endcase
  end

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_alu_src    = 1'b0;
    w_result_src = 2'b00;
    w_alu_ctl    = c_ALU_ADD;
    w_imm        = '0;
    case (w_opcode)
      c_OP_LOAD: begin
        w_reg_write = 1'b1; w_alu_src = 1'b1; w_result_src = 2'b01; w_imm = w_imm_i;
      end
      c_OP_STORE: begin
        w_mem_write = 1'b1; w_alu_src = 1'b1; w_imm = w_imm_s;
      end
      c_OP_RTYPE: begin
        w_reg_write = 1'b1; w_alu_ctl = w_alu_func;
      end
      c_OP_IALU: begin
        w_reg_write = 1'b1; w_alu_src = 1'b1; w_imm = w_imm_i; w_alu_ctl = w_alu_func;
      end
      c_OP_BRANCH: begin
        w_branch = 1'b1; w_imm = w_imm_b; w_alu_ctl = c_ALU_SUB;
      end
      c_OP_JAL: begin
        w_jump = 1'b1; w_reg_write = 1'b1; w_result_src = 2'b10; w_imm = w_imm_j;
      end
      c_OP_JALR: begin
        w_jump = 1'b1; w_reg_write = 1'b1; w_alu_src = 1'b1;
        w_result_src = 2'b10; w_imm = w_imm_i;
      end
      c_OP_LUI: begin
        w_reg_write = 1'b1; w_alu_src = 1'b1; w_imm = w_imm_u; w_alu_ctl = c_ALU_PASS;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file with writeback bypass. Entry 0 is never written, and the
  // read path also forces x0 to zero so a bypass can never leak into it.
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_regs [32];
  logic                  w_wb_en;
  logic [ADDR_WIDTH-1:0] w_rd1, w_rd2;

  assign w_wb_en = RegWrite_W && (Rd_W != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[Rd_W] <= Result_W;
    end
  end

  assign w_rd1 = (Rs1_D == 5'd0)                ? '0       :
                 (w_wb_en && (Rd_W == Rs1_D))   ? Result_W : r_regs[Rs1_D];
  assign w_rd2 = (Rs2_D == 5'd0)                ? '0       :
                 (w_wb_en && (Rd_W == Rs2_D))   ? Result_W : r_regs[Rs2_D];

  // --------------------------------------------------------------------------
  // ID/EX pipeline register
  // --------------------------------------------------------------------------
  logic w_bubble;
  assign w_bubble = PCSrc_E || ID_EX_Flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      RegWrite_E   <= 1'b0;
      MemWrite_E   <= 1'b0;
      Jump_E       <= 1'b0;
      Branch_E     <= 1'b0;
      ALUSrc_E     <= 1'b0;
      ResultSrc_E  <= 2'b00;
      ALUControl_E <= 3'b000;
      funct3_E     <= 3'b000;
      RD1_E        <= '0;
      RD2_E        <= '0;
      Imm_Ext_E    <= '0;
      PC_E         <= '0;
      PC_4E        <= '0;
      Rd_E         <= 5'd0;
      Rs1_E        <= 5'd0;
      Rs2_E        <= 5'd0;
    end else begin
      RegWrite_E   <= w_reg_write;
      MemWrite_E   <= w_mem_write;
      Jump_E       <= w_jump;
      Branch_E     <= w_branch;
      ALUSrc_E     <= w_alu_src;
      ResultSrc_E  <= w_result_src;
      ALUControl_E <= w_alu_ctl;
      funct3_E     <= w_funct3;
      RD1_E        <= w_rd1;
      RD2_E        <= w_rd2;
      Imm_Ext_E    <= w_imm;
      PC_E         <= PC_D;
      PC_4E        <= PC_4D;
      Rd_E         <= w_rd;
      Rs1_E        <= Rs1_D;
      Rs2_E        <= Rs2_D;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Self-checking bench for decode_stage. Expected ID/EX contents are
//            pushed to a queue when an instruction is driven and compared
//            after the capturing edge.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Ins_D, PC_D, PC_4D, Result_W;
  logic        RegWrite_W, PCSrc_E, ID_EX_Flush;
  logic [4:0]  Rd_W;
  logic [4:0]  Rs1_D, Rs2_D, Rd_E, Rs1_E, Rs2_E;
  logic        RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E;
  logic [1:0]  ResultSrc_E;
  logic [2:0]  ALUControl_E, funct3_E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PC_4E;

  always #5 clk = ~clk;

  decode_stage #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .Ins_D(Ins_D), .PC_D(PC_D), .PC_4D(PC_4D),
    .RegWrite_W(RegWrite_W), .Rd_W(Rd_W), .Result_W(Result_W),
    .PCSrc_E(PCSrc_E), .ID_EX_Flush(ID_EX_Flush),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .Jump_E(Jump_E),
    .Branch_E(Branch_E), .ALUSrc_E(ALUSrc_E), .ResultSrc_E(ResultSrc_E),
    .ALUControl_E(ALUControl_E), .funct3_E(funct3_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PC_E(PC_E), .PC_4E(PC_4E),
    .Rd_E(Rd_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E)
  );

  typedef struct packed {
    logic        rw, mw, j, b, as;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [2:0]  f3;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
  } exp_t;

  exp_t        r_sb_q [$];
  logic [31:0] r_model [32];
  int          r_n_vec  = 0;
  int          r_n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    r_n_vec++;
    if (obs !== expv) begin
      r_n_miss++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    chk("RegWrite_E",   32'(RegWrite_E),   32'(e.rw));
    chk("MemWrite_E",   32'(MemWrite_E),   32'(e.mw));
    chk("Jump_E",       32'(Jump_E),       32'(e.j));
    chk("Branch_E",     32'(Branch_E),     32'(e.b));
    chk("ALUSrc_E",     32'(ALUSrc_E),     32'(e.as));
    chk("ResultSrc_E",  32'(ResultSrc_E),  32'(e.rs));
    chk("ALUControl_E", 32'(ALUControl_E), 32'(e.alu));
    chk("funct3_E",     32'(funct3_E),     32'(e.f3));
    chk("RD1_E",        RD1_E,             e.rd1);
    chk("RD2_E",        RD2_E,             e.rd2);
    chk("Imm_Ext_E",    Imm_Ext_E,         e.imm);
    chk("PC_E",         PC_E,              e.pc);
    chk("PC_4E",        PC_4E,             e.pc4);
    chk("Rd_E",         32'(Rd_E),         32'(e.rd));
    chk("Rs1_E",        32'(Rs1_E),        32'(e.rs1));
    chk("Rs2_E",        32'(Rs2_E),        32'(e.rs2));
  endtask

  // Control-only expectation; index, operand and PC fields are filled in drive.
  function automatic exp_t ctl(input logic rw, mw, j, b, as, input logic [1:0] rs,
                               input logic [2:0] alu, input logic [31:0] imm);
    exp_t e = '0;
    e.rw = rw; e.mw = mw; e.j = j; e.b = b; e.as = as;
    e.rs = rs; e.alu = alu; e.imm = imm;
    return e;
  endfunction

  // Check whatever the previous edge captured, then drive the next decode.
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic wen, input logic [4:0] wrd, input logic [31:0] wdata,
                       input logic pcsrc, input logic flush, input exp_t c);
    exp_t        e;
    logic [4:0]  s1, s2;
    @(negedge clk);
    if (r_sb_q.size() > 0) compare_outputs(r_sb_q.pop_front());
    Ins_D = ins; PC_D = pc; PC_4D = pc + 32'd4;
    RegWrite_W = wen; Rd_W = wrd; Result_W = wdata;
    PCSrc_E = pcsrc; ID_EX_Flush = flush;
    s1 = ins[19:15];
    s2 = ins[24:20];
    #1;
    chk("Rs1_D", 32'(Rs1_D), 32'(s1));
    chk("Rs2_D", 32'(Rs2_D), 32'(s2));
    if (pcsrc || flush) begin
      e = '0;
    end else begin
      e      = c;
      e.f3   = ins[14:12];
      e.rd   = ins[11:7];
      e.rs1  = s1;
      e.rs2  = s2;
      e.pc   = pc;
      e.pc4  = pc + 32'd4;
      e.rd1  = (s1 == 0) ? 32'd0 : (wen && wrd == s1) ? wdata : r_model[s1];
      e.rd2  = (s2 == 0) ? 32'd0 : (wen && wrd == s2) ? wdata : r_model[s2];
    end
    r_sb_q.push_back(e);
    if (wen && wrd != 0) r_model[wrd] = wdata;
  endtask

  task automatic drain();
    @(negedge clk);
    while (r_sb_q.size() > 0) compare_outputs(r_sb_q.pop_front());
  endtask

  exp_t c_r_add, c_zero;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [4:0]  wr, a, b;
    logic [31:0] wd;
    for (int i = 0; i < 32; i++) r_model[i] = 32'd0;
    c_zero  = '0;
    c_r_add = ctl(1, 0, 0, 0, 0, 2'b00, 3'b000, 32'd0);
    rst_n = 1'b0;
    Ins_D = '0; PC_D = '0; PC_4D = '0; RegWrite_W = 0; Rd_W = '0; Result_W = '0;
    PCSrc_E = 0; ID_EX_Flush = 0;
    #12;
    compare_outputs(c_zero);
    @(negedge clk);
    rst_n = 1'b1;

    // zero word, add x6,x5,x0 with bypassed write of x5
    drive(32'h0000_0000, 32'h0, 0, 0, 0, 0, 0, c_zero);
    drive(32'h0002_8333, 32'h4, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, c_r_add);
    // NOP (addi x0) while writing x1, then sw x2,8(x1) bypassing x2
    drive(32'h0000_0013, 32'h8, 1, 5'd1, 32'h0000_0100, 0, 0, ctl(1,0,0,0,1,2'b00,3'b000,32'd0));
    drive(32'h0020_A423, 32'hC, 1, 5'd2, 32'h0000_0055, 0, 0, ctl(0,1,0,0,1,2'b00,3'b000,32'd8));
    // beq x0,x0,-4
    drive(32'hFE00_0EE3, 32'h40, 0, 0, 0, 0, 0, ctl(0,0,0,1,0,2'b00,3'b001,32'hFFFF_FFFC));
    // add x7,x1,x2: PCSrc flush, ID_EX flush with concurrent write of x3, then normal
    drive(32'h0020_83B3, 32'h44, 0, 0, 0, 1, 0, c_r_add);
    drive(32'h0020_83B3, 32'h44, 1, 5'd3, 32'h0000_0077, 0, 1, c_r_add);
    drive(32'h0020_83B3, 32'h48, 0, 0, 0, 0, 0, c_r_add);
    // writes to x0 are discarded
    drive(32'h0000_03B3, 32'h4C, 1, 5'd0, 32'h0000_1234, 0, 0, c_r_add);
    drive(32'h0000_03B3, 32'h50, 0, 0, 0, 0, 0, c_r_add);
    drive(32'h0030_03B3, 32'h54, 0, 0, 0, 0, 0, c_r_add);
    // lui, jal, jalr, lw, andi, sub, sll, addi with bit30 set, unknown opcode
    drive(32'hABCD_E237, 32'h58, 0, 0, 0, 0, 0, ctl(1,0,0,0,1,2'b00,3'b111,32'hABCD_E000));
    drive(32'h0100_00EF, 32'h5C, 0, 0, 0, 0, 0, ctl(1,0,1,0,0,2'b10,3'b000,32'd16));
    drive(32'hFFC0_8067, 32'h60, 0, 0, 0, 0, 0, ctl(1,0,1,0,1,2'b10,3'b000,32'hFFFF_FFFC));
    drive(32'hFFF1_2283, 32'h64, 0, 0, 0, 0, 0, ctl(1,0,0,0,1,2'b01,3'b000,32'hFFFF_FFFF));
    drive(32'h0F00_F313, 32'h68, 0, 0, 0, 0, 0, ctl(1,0,0,0,1,2'b00,3'b010,32'h0000_00F0));
    drive(32'h4020_8433, 32'h6C, 0, 0, 0, 0, 0, ctl(1,0,0,0,0,2'b00,3'b001,32'd0));
    drive(32'h0020_9433, 32'h70, 0, 0, 0, 0, 0, ctl(1,0,0,0,0,2'b00,3'b110,32'd0));
    drive(32'h0020_A433, 32'h74, 0, 0, 0, 0, 0, ctl(1,0,0,0,0,2'b00,3'b101,32'd0));
    drive(32'h0020_C433, 32'h78, 0, 0, 0, 0, 0, ctl(1,0,0,0,0,2'b00,3'b100,32'd0));
    drive(32'h0020_E433, 32'h7C, 0, 0, 0, 0, 0, ctl(1,0,0,0,0,2'b00,3'b011,32'd0));
    drive(32'h0020_B433, 32'h80, 0, 0, 0, 0, 0, ctl(1,0,0,0,0,2'b00,3'b000,32'd0));
    drive(32'hC000_0493, 32'h84, 0, 0, 0, 0, 0, ctl(1,0,0,0,1,2'b00,3'b000,32'hFFFF_FC00));
    drive(32'hFFFF_FFFF, 32'h88, 0, 0, 0, 0, 0, c_zero);

    // random register traffic through R-type adds
    for (int k = 0; k < 12; k++) begin
      wr = 5'($urandom_range(0, 31));
      a  = 5'($urandom_range(0, 31));
      b  = 5'($urandom_range(0, 31));
      wd = $urandom;
      drive({7'd0, b, a, 3'b000, 5'd9, 7'b0110011}, 32'h100 + 32'(k*4),
            1'b1, wr, wd, 0, 0, c_r_add);
    end
    drain();

    // asynchronous reset mid-operation clears ID/EX and the register file
    drive(32'h0020_83B3, 32'h200, 0, 0, 0, 0, 0, c_r_add);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    compare_outputs(c_zero);
    for (int i = 0; i < 32; i++) r_model[i] = 32'd0;
    @(negedge clk);
    compare_outputs(c_zero);
    rst_n = 1'b1;
    drive(32'h0020_83B3, 32'h204, 0, 0, 0, 0, 0, c_r_add);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", r_n_vec, r_n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Decode stage of the 5-stage RV32I pipeline. It consumes the IF/ID pipeline register driven by the fetch stage (Ins_D, PC_D, PC_4D) and decodes the instruction into control signals and a sign-extended immediate. It also holds the 32×32 register file, with a writeback port and same-cycle write-through, and registers everything into the ID/EX pipeline register. ID/EX is flushed on a taken branch/jump (PCSrc_E) or on a hazard-unit bubble request.

## Interface
- ADDR_WIDTH, 32, width of PC, instruction and data paths
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Ins_D / PC_D / PC_4D  in  ADDR_WIDTH each  IF/ID instruction, PC, PC+4
- RegWrite_W  in  1  writeback enable
- Rd_W  in  5  writeback register index
- Result_W  in  ADDR_WIDTH  writeback data
- PCSrc_E  in  1  taken branch/jump in EX; flush ID/EX
- ID_EX_Flush  in  1  load-use bubble from hazard unit; flush ID/EX
- Rs1_D / Rs2_D  out  5 each  combinational Ins_D[19:15] / Ins_D[24:20], to hazard unit
- RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E  out  1 each  registered controls
- ResultSrc_E  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControl_E  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 pass-B
- funct3_E  out  3  branch condition select
- RD1_E / RD2_E / Imm_Ext_E / PC_E / PC_4E  out  ADDR_WIDTH each  registered operands
- Rd_E / Rs1_E / Rs2_E  out  5 each  registered register indices

## Operation
- Register file: 32×ADDR_WIDTH. Every entry is cleared on reset. x0 always reads 0, and writes to x0 are discarded.
- Write: at the rising edge when RegWrite_W=1 and Rd_W≠0.
- Read bypass: if RegWrite_W=1, Rd_W≠0 and Rd_W equals the read index, the read returns Result_W in the same cycle.
- Decoding is by opcode. Anything not listed below decodes to all-zero controls, with Imm_Ext=0.
  - lw 0000011: RegWrite, ALUSrc, ResultSrc=01, I-imm, add.
  - sw 0100011: MemWrite, ALUSrc, S-imm, add.
  - R 0110011: RegWrite; ALU operation from funct3/funct7[5].
  - I-ALU 0010011: RegWrite, ALUSrc, I-imm; ALU operation from funct3 (no sub).
  - branch 1100011: Branch, B-imm, sub.
  - jal 1101111: Jump, RegWrite, ResultSrc=10, J-imm.
  - jalr 1100111: Jump, RegWrite, ALUSrc, ResultSrc=10, I-imm, add.
  - lui 0110111: RegWrite, ALUSrc, U-imm, pass-B.
- ALU operation map for R/I by funct3:
  - 000: add, or sub when R-type and funct7[5]=1.
  - 001: sll.
  - 010: slt.
  - 100: xor.
  - 110: or.
  - 111: and.
  - Other funct3 values: add.
- Immediates are sign-extended from bit 31. B and J immediates have LSB 0. U immediate is {Ins[31:12], 12'b0}.
- ID/EX register update, in priority order:
  1. rst_n low: all outputs 0.
  2. PCSrc_E=1 or ID_EX_Flush=1: all outputs 0 (bubble).
  3. Otherwise: capture decoded values, PC_D, PC_4D and the register reads.
- ID/EX has no stall input. A load-use stall inserts the bubble via ID_EX_Flush while fetch holds IF/ID.
- The NOP 0x00000013 decodes as addi x0 with RegWrite_E=1 and Rd_E=0, which is harmless.

## Timing
- Register read to RD1_E/RD2_E: 1 cycle.
- Writeback: Result_W is visible to a decode in the same cycle through the bypass, and in the array from the next cycle.
- Rs1_D/Rs2_D are purely combinational from Ins_D, with zero latency.
- Flush takes effect at the next rising edge. When flush and a writeback occur together, the register file is still written.
- Reset mid-operation clears ID/EX and the register file immediately (asynchronous). Outputs stay 0 until the first edge after rst_n rises.
- All register-file arithmetic is ADDR_WIDTH bits, with no overflow handling.

## Test plan
- Reset, then Ins_D=0x00000000 → after one edge, all outputs are 0 and ALUControl_E=000.
- Set Ins_D=0x00028333 (add x6,x5,x0) with RegWrite_W=1, Rd_W=5, Result_W=0xDEADBEEF in the same cycle → next edge: RD1_E=0xDEADBEEF, Rd_E=6, RegWrite_E=1, ALUControl_E=000.
- Ins_D=0x0020A423 (sw x2,8(x1)) → MemWrite_E=1, RegWrite_E=0, ALUSrc_E=1, Imm_Ext_E=0x00000008, Rs1_E=1, Rs2_E=2.
- Ins_D=0xFE000EE3 (beq x0,x0,-4), PC_D=0x40 → Branch_E=1, ALUControl_E=001, Imm_Ext_E=0xFFFFFFFC, PC_E=0x40, funct3_E=000.
- Valid add in decode with PCSrc_E=1 (repeat with ID_EX_Flush=1) → next edge: all ID/EX outputs 0. Without flush, the following cycle decodes normally.
- RegWrite_W=1, Rd_W=0, Result_W=0x1234 while decoding add x7,x0,x0 → RD1_E=RD2_E=0 in that cycle and on every later read of x0.
